// File: rtl/counter_pkg.sv
// Shared constants and helpers for the up/down modulo counter family.
package counter_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // Bits needed to hold 0..n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides enabled cycles by PRESCALE and emits one step per completed period.
module tick_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic CLK,
    input  logic RST,
    input  logic Enable,
    input  logic restart,
    output logic step
);

    generate
        if (PRESCALE == 1) begin : g_direct
            wire unused_in = &{1'b0, CLK, RST, restart};
            assign step = Enable;
        end else begin : g_div
            localparam int PW = cnt_width(PRESCALE);
            localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
            localparam logic [PW-1:0] ONE  = PW'(1);

            logic [PW-1:0] pre_cnt;

            // Enable low freezes the phase; restart realigns the period.
            always_ff @(posedge CLK) begin
                if (RST || restart) begin
                    pre_cnt <= '0;
                end else if (Enable) begin
                    pre_cnt <= (pre_cnt == LAST) ? '0 : pre_cnt + ONE;
                end
            end

            assign step = Enable && (pre_cnt == LAST);
        end
    endgenerate

endmodule

// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with prescaler, load, clear and terminal-count pulse.
// Optional sticky Overflow flag when COUNTER_STICKY_OVF_EN is defined.
module updown_mod_counter
    import counter_pkg::*;
#(
    parameter int VALUE_WIDTH = 8,
    parameter int MODULUS     = 256,
    parameter int PRESCALE    = 1,
    parameter int SATURATE    = 0
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   Enable,
    input  logic                   Up,
    input  logic                   Clear,
    input  logic                   Load,
    input  logic [VALUE_WIDTH-1:0] LoadValue,
    output logic [VALUE_WIDTH-1:0] value,
    output logic                   TC,
    output logic                   AtMax,
`ifdef COUNTER_STICKY_OVF_EN
    output logic                   AtZero,
    output logic                   Overflow
`else
    output logic                   AtZero
`endif
);

    localparam logic [VALUE_WIDTH-1:0] MAX_V = VALUE_WIDTH'(MODULUS - 1);
    localparam logic [VALUE_WIDTH-1:0] ONE_V = VALUE_WIDTH'(1);
    localparam bit                     SAT   = (SATURATE != MODE_WRAP);

    logic                   step;
    logic [VALUE_WIDTH-1:0] value_nxt;
    logic [VALUE_WIDTH-1:0] load_clamped;
    logic                   tc_nxt;

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_pre (
        .CLK     (CLK),
        .RST     (RST),
        .Enable  (Enable),
        .restart (Clear | Load),
        .step    (step)
    );

    assign AtMax        = (value == MAX_V);
    assign AtZero       = (value == '0);
    assign load_clamped = (LoadValue > MAX_V) ? MAX_V : LoadValue;

    // Bound crossings target explicit 0 / MAX_V, never binary rollover.
    always_comb begin
        value_nxt = value;
        tc_nxt    = 1'b0;
        if (Clear) begin
            value_nxt = '0;
        end else if (Load) begin
            value_nxt = load_clamped;
        end else if (step) begin
            if (Up == DIR_UP) begin
                if (AtMax) begin
                    tc_nxt    = 1'b1;
                    value_nxt = SAT ? MAX_V : '0;
                end else begin
                    value_nxt = value + ONE_V;
                end
            end else begin
                if (AtZero) begin
                    tc_nxt    = 1'b1;
                    value_nxt = SAT ? '0 : MAX_V;
                end else begin
                    value_nxt = value - ONE_V;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            value <= '0;
            TC    <= 1'b0;
        end else begin
            value <= value_nxt;
            TC    <= tc_nxt;
        end
    end

`ifdef COUNTER_STICKY_OVF_EN
    always_ff @(posedge CLK) begin
        if (RST || Clear) begin
            Overflow <= 1'b0;
        end else if (tc_nxt) begin
            Overflow <= 1'b1;
        end
    end
`endif

endmodule
